// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg
//   Shared definitions for the RV32I decode control path: major opcodes,
//   ALU operation codes, immediate / result-source encodings, the packed
//   ID/EX control bundle and a small funct3-to-ALU helper.
//   Optional feature macro (used by importers): DECODE_MEXT_EN.
package core_ctrl_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // funct7 patterns of interest for R-type
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // ALU operation codes; the bundle carries them in ALU_CODE_W bits and the
  // top widens them to the configured output width.
  localparam int ALU_CODE_W = 4;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_AND   = 4'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_OR    = 4'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_PASSB = 4'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT   = 4'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR   = 4'd6;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL   = 4'd7;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL   = 4'd8;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA   = 4'd9;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU  = 4'd10;
  localparam logic [ALU_CODE_W-1:0] ALU_MUL   = 4'd11;
  localparam logic [ALU_CODE_W-1:0] ALU_MULH  = 4'd12;
  localparam logic [ALU_CODE_W-1:0] ALU_DIV   = 4'd13;
  localparam logic [ALU_CODE_W-1:0] ALU_REM   = 4'd14;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Writeback result select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  alu_src;
    logic                  alu_a_pc;
    logic                  jump;
    logic                  jump_sel;
    logic                  branch;
    logic [2:0]            branch_type;
    logic [1:0]            result_src;
    logic [2:0]            imm_src;
    logic [ALU_CODE_W-1:0] alu_op;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
  } ctrl_bundle_t;

  // Shared funct3 decode for the register and immediate ALU groups. 'alt'
  // is instr[30]; it only matters for the right shifts here, the R-type
  // SUB case is handled by the caller because I-type never subtracts.
  function automatic logic [ALU_CODE_W-1:0] alu_from_f3(input logic [2:0] f3,
                                                         input logic       alt);
    logic [ALU_CODE_W-1:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// decode_ctrl_comb
//   Pure combinational RV32I control decode: instruction word in, control
//   bundle plus illegal flag out. The bundle contents are don't-care when
//   illegal is set; the register stage never loads it in that case.
//   Macro DECODE_MEXT_EN: when defined, R-type funct7=0000001 decodes the
//   MUL/MULH/DIV/REM subset; otherwise that funct7 is illegal.
// Ports:
//   instr   in  32  instruction word
//   bundle  out     decoded ctrl_bundle_t
//   illegal out 1   instruction is not supported
module decode_ctrl_comb
  import core_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t bundle,
  output logic         illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    bundle             = '0;
    illegal            = 1'b0;
    // Register indices are passed through for every format; unused ones are
    // harmless to the execute stage.
    bundle.rd          = instr[11:7];
    bundle.rs1         = instr[19:15];
    bundle.rs2         = instr[24:20];
    bundle.alu_op      = ALU_ADD;
    bundle.imm_src     = IMM_I;
    bundle.result_src  = RES_ALU;

    case (opcode)
      OP_LOAD: begin
        bundle.reg_write  = 1'b1;
        bundle.alu_src    = 1'b1;
        bundle.result_src = RES_MEM;
      end

      OP_STORE: begin
        bundle.mem_write = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.imm_src   = IMM_S;
      end

      OP_RTYPE: begin
        bundle.reg_write = 1'b1;
        if (funct7 == F7_BASE) begin
          bundle.alu_op = alu_from_f3(funct3, 1'b0);
        end else if (funct7 == F7_ALT) begin
          bundle.alu_op = (funct3 == 3'b000) ? ALU_SUB : alu_from_f3(funct3, 1'b1);
`ifdef DECODE_MEXT_EN
        end else if (funct7 == F7_MEXT) begin
          case (funct3)
            3'b000:  bundle.alu_op = ALU_MUL;
            3'b001:  bundle.alu_op = ALU_MULH;
            3'b100:  bundle.alu_op = ALU_DIV;
            3'b110:  bundle.alu_op = ALU_REM;
            default: illegal = 1'b1;
          endcase
`endif
        end else begin
          illegal = 1'b1;
        end
      end

      OP_ITYPE: begin
        bundle.reg_write = 1'b1;
        bundle.alu_src   = 1'b1;
        bundle.alu_op    = alu_from_f3(funct3, instr[30]);
      end

      OP_BRANCH: begin
        bundle.branch      = 1'b1;
        bundle.imm_src     = IMM_B;
        bundle.branch_type = funct3;
        // funct3[2:1] groups eq/ne, lt/ge and ltu/geu; 01x is unassigned.
        case (funct3[2:1])
          2'b00:   bundle.alu_op = ALU_SUB;
          2'b10:   bundle.alu_op = ALU_SLT;
          2'b11:   bundle.alu_op = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end

      OP_JAL: begin
        bundle.reg_write  = 1'b1;
        bundle.jump       = 1'b1;
        bundle.imm_src    = IMM_J;
        bundle.result_src = RES_PC4;
      end

      OP_JALR: begin
        bundle.reg_write  = 1'b1;
        bundle.alu_src    = 1'b1;
        bundle.jump       = 1'b1;
        bundle.jump_sel   = 1'b1;
        bundle.result_src = RES_PC4;
      end

      OP_LUI: begin
        bundle.reg_write = 1'b1;
        bundle.imm_src   = IMM_U;
        bundle.alu_op    = ALU_PASSB;
      end

      OP_AUIPC: begin
        bundle.reg_write = 1'b1;
        bundle.imm_src   = IMM_U;
        bundle.alu_a_pc  = 1'b1;
      end

      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage
//   Registered ID/EX control stage. Accepts an instruction over a
//   valid/ready handshake, decodes it through decode_ctrl_comb and holds the
//   control bundle in an output register until the execute stage takes it.
//   An accepted illegal instruction becomes a bubble, bumps a saturating
//   counter and parks the stage in HALTED until reset.
//   Macro DECODE_MEXT_EN (see decode_ctrl_comb) enables M-extension decode.
// Parameters:
//   ALU_CTRL_W  ALU control output width (>= 4)
//   CNT_W       illegal-instruction counter width
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/instr   instruction handshake
//   flush                     drop held bundle, block acceptance this cycle
//   out_valid/out_ready       bundle handshake toward execute
//   reg_write .. rs2          registered control bundle
//   halted                    sticky illegal-opcode halt
//   illegal_cnt               saturating illegal acceptance count
module decode_ctrl_stage
  import core_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  reg_write,
  output logic                  mem_write,
  output logic                  alu_src,
  output logic                  alu_a_pc,
  output logic                  jump,
  output logic                  jump_sel,
  output logic                  branch,
  output logic [2:0]            branch_type,
  output logic [1:0]            result_src,
  output logic [2:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [4:0]            rd,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic                  halted,
  output logic [CNT_W-1:0]      illegal_cnt
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t       state;
  state_t       state_next;
  ctrl_bundle_t bundle_p0;
  logic         illegal_p0;
  logic         accept_p0;
  ctrl_bundle_t bundle_p1;
  logic         vld_p1;
  logic [CNT_W-1:0] cnt_p1;

  decode_ctrl_comb u_decode (
    .instr   (instr),
    .bundle  (bundle_p0),
    .illegal (illegal_p0)
  );

  // Handshake and next state. in_ready is forced low during reset so nothing
  // is offered as accepted on a cycle whose edge will clear the stage.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept_p0  = 1'b0;
    case (state)
      ST_RUN: begin
        in_ready  = !rst && !flush && (!vld_p1 || out_ready);
        accept_p0 = in_valid && in_ready;
        if (accept_p0 && illegal_p0) begin
          state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        in_ready   = 1'b0;
        state_next = ST_HALTED;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // ---- stage p0 -> p1: output register ----
  // An illegal acceptance is a bubble: it may still retire the old bundle
  // (acceptance implies either empty or consumed) but never sets valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= '0;
      cnt_p1    <= '0;
    end else begin
      if (flush) begin
        vld_p1 <= 1'b0;
      end else if (accept_p0 && !illegal_p0) begin
        vld_p1 <= 1'b1;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end

      if (accept_p0 && !illegal_p0) begin
        bundle_p1 <= bundle_p0;
      end

      if (accept_p0 && illegal_p0 && (cnt_p1 != {CNT_W{1'b1}})) begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
    end
  end

  assign out_valid   = vld_p1;
  assign reg_write   = bundle_p1.reg_write;
  assign mem_write   = bundle_p1.mem_write;
  assign alu_src     = bundle_p1.alu_src;
  assign alu_a_pc    = bundle_p1.alu_a_pc;
  assign jump        = bundle_p1.jump;
  assign jump_sel    = bundle_p1.jump_sel;
  assign branch      = bundle_p1.branch;
  assign branch_type = bundle_p1.branch_type;
  assign result_src  = bundle_p1.result_src;
  assign imm_src     = bundle_p1.imm_src;
  assign alu_ctrl    = ALU_CTRL_W'(bundle_p1.alu_op);
  assign rd          = bundle_p1.rd;
  assign rs1         = bundle_p1.rs1;
  assign rs2         = bundle_p1.rs2;
  assign halted      = (state == ST_HALTED);
  assign illegal_cnt = cnt_p1;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Testbench for decode_ctrl_stage: scoreboard of expected control bundles,
// filled from an independent reference decode on acceptance and drained as
// the stage delivers, plus direct checks of the listed scenarios.
module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        reg_write, mem_write, alu_src, alu_a_pc, jump, jump_sel, branch;
  logic [2:0]  branch_type;
  logic [1:0]  result_src;
  logic [2:0]  imm_src;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd, rs1, rs2;
  logic        halted;
  logic [7:0]  illegal_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [33:0] sb_q[$];
  logic        halt_m;
  logic [7:0]  cnt_m;
  logic [33:0] got_b;

  always #5 clk = ~clk;

  decode_ctrl_stage #(.ALU_CTRL_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .reg_write(reg_write), .mem_write(mem_write), .alu_src(alu_src),
    .alu_a_pc(alu_a_pc), .jump(jump), .jump_sel(jump_sel), .branch(branch),
    .branch_type(branch_type), .result_src(result_src), .imm_src(imm_src),
    .alu_ctrl(alu_ctrl), .rd(rd), .rs1(rs1), .rs2(rs2), .halted(halted),
    .illegal_cnt(illegal_cnt)
  );

  assign got_b = {reg_write, mem_write, alu_src, alu_a_pc, jump, jump_sel, branch,
                  branch_type, result_src, imm_src, alu_ctrl, rd, rs1, rs2};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: {illegal, bundle bits in got_b order}
  function automatic logic [34:0] model(input logic [31:0] i);
    logic [6:0] op, f7;
    logic [2:0] f3, bt, is;
    logic [1:0] rs;
    logic [3:0] alu;
    logic rw, mw, as, apc, j, js, br, ill;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    rw = 0; mw = 0; as = 0; apc = 0; j = 0; js = 0; br = 0; ill = 0;
    bt = 0; is = 0; rs = 0; alu = 0;
    case (op)
      7'h03: begin rw = 1; as = 1; rs = 2'b01; end
      7'h23: begin mw = 1; as = 1; is = 3'd1; end
      7'h33: begin
        rw = 1;
        if (f7 == 7'h00) alu = base_alu(f3, 1'b0);
        else if (f7 == 7'h20) alu = (f3 == 3'd0) ? 4'd1 : base_alu(f3, 1'b1);
        else if (f7 == 7'h01) begin
`ifdef DECODE_MEXT_EN
          if (f3 == 3'd0) alu = 4'd11;
          else if (f3 == 3'd1) alu = 4'd12;
          else if (f3 == 3'd4) alu = 4'd13;
          else if (f3 == 3'd6) alu = 4'd14;
          else ill = 1;
`else
          ill = 1;
`endif
        end else ill = 1;
      end
      7'h13: begin rw = 1; as = 1; alu = base_alu(f3, i[30]); end
      7'h63: begin
        br = 1; is = 3'd2; bt = f3;
        if (f3 == 3'd0 || f3 == 3'd1) alu = 4'd1;
        else if (f3 == 3'd4 || f3 == 3'd5) alu = 4'd5;
        else if (f3 == 3'd6 || f3 == 3'd7) alu = 4'd10;
        else ill = 1;
      end
      7'h6F: begin rw = 1; j = 1; is = 3'd3; rs = 2'b10; end
      7'h67: begin rw = 1; as = 1; j = 1; js = 1; rs = 2'b10; end
      7'h37: begin rw = 1; is = 3'd4; alu = 4'd4; end
      7'h17: begin rw = 1; is = 3'd4; apc = 1; end
      default: ill = 1;
    endcase
    return {ill, rw, mw, as, apc, j, js, br, bt, rs, is, alu, i[11:7], i[19:15], i[24:20]};
  endfunction

  function automatic logic [3:0] base_alu(input logic [2:0] f3, input logic sra);
    logic [3:0] r;
    case (f3)
      3'd0: r = 4'd0;
      3'd1: r = 4'd7;
      3'd2: r = 4'd5;
      3'd3: r = 4'd10;
      3'd4: r = 4'd6;
      3'd5: r = sra ? 4'd9 : 4'd8;
      3'd6: r = 4'd3;
      default: r = 4'd2;
    endcase
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; flush = 0; out_ready = 0; instr = '0;
    #1;
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_bundle", got_b, 0);
    check("rst_halted", halted, 0);
    check("rst_cnt", illegal_cnt, 0);
    sb_q.delete();
    halt_m = 0;
    cnt_m = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                      input logic fl, output logic acc);
    logic [34:0] m;
    logic exp_ir;
    @(negedge clk);
    in_valid = v; instr = ins; out_ready = ordy; flush = fl;
    #1;
    exp_ir = !halt_m && !fl && (sb_q.size() == 0 || ordy);
    check("in_ready", in_ready, exp_ir);
    check("out_valid", out_valid, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      check("bundle", got_b, sb_q[0]);
      if (fl || ordy) void'(sb_q.pop_front());
    end
    acc = v && exp_ir;
    if (acc) begin
      m = model(ins);
      if (m[34]) begin
        halt_m = 1;
        if (cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
      end else begin
        sb_q.push_back(m[33:0]);
      end
    end
    @(posedge clk);
    #1;
    check("halted", halted, halt_m);
    check("illegal_cnt", illegal_cnt, cnt_m);
  endtask

  // Offer an instruction with random out_ready until accepted (bounded).
  task automatic send(input logic [31:0] ins);
    logic acc;
    acc = 0;
    for (int k = 0; k < 20 && !acc; k++) begin
      step(1'b1, ins, 1'(($urandom_range(0, 3) != 0)), 1'b0, acc);
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  logic [31:0] legal_tab[] = '{
    32'h0080A283, 32'h0020A623, 32'hFFF08213, 32'h00309313, 32'h4020D393,
    32'h0020D393, 32'h0FF0C213, 32'h0010B213, 32'h0020B1B3, 32'h4020D1B3,
    32'h0020F1B3, 32'h0020C1B3, 32'h4020C1B3, 32'h0020A1B3, 32'h0020E1B3,
    32'h010000EF, 32'h000280E7, 32'h123452B7, 32'h12345297, 32'h00209463,
    32'h0020C463, 32'h0020D463, 32'h0020E463, 32'h0020F463
  };
  logic [31:0] illegal_tab[] = '{
    32'h0000007F, 32'h0020A463, 32'h0020B463, 32'h202081B3, 32'h0220A1B3,
    32'h00000000
  };

  initial begin
    logic acc;
    rst = 1; in_valid = 0; flush = 0; out_ready = 0; instr = '0;
    halt_m = 0; cnt_m = 0;
    do_reset();

    // Back-to-back add then sub
    step(1, 32'h002081B3, 1, 0, acc);
    check("add_acc", acc, 1);
    check("add_alu", alu_ctrl, 4'd0);
    check("add_rd", rd, 5'd3);
    step(1, 32'h402081B3, 1, 0, acc);
    check("sub_alu", alu_ctrl, 4'd1);
    check("sub_rd", rd, 5'd3);

    // beq held for 3 cycles with the sink stalled
    step(1, 32'h00208463, 1, 0, acc);
    for (int k = 0; k < 3; k++) begin
      step(1, 32'h002081B3, 0, 0, acc);
      check("beq_hold_in_ready", in_ready, 0);
      check("beq_fields", {out_valid, branch, branch_type, imm_src}, 8'b1_1_000_010);
    end
    step(0, 32'h0, 1, 0, acc);

    // Mixed legal instructions with random back-pressure
    foreach (legal_tab[n]) send(legal_tab[n]);
    step(0, 32'h0, 1, 0, acc);

    // Flush while holding: bundle dropped, offered instr not taken
    send(32'hFFF08213);
    step(1, 32'h123452B7, 0, 1, acc);
    check("flush_ov", out_valid, 0);
    // Flush wins over out_ready
    step(1, 32'h00309313, 1, 0, acc);
    step(1, 32'h12345297, 1, 1, acc);
    check("flush_prio_ov", out_valid, 0);
    step(0, 32'h0, 1, 0, acc);

    // mul with and without M-extension
    step(1, 32'h022081B3, 1, 0, acc);
`ifdef DECODE_MEXT_EN
    check("mul_alu", alu_ctrl, 4'd11);
    send(32'h022091B3);
    send(32'h0220C1B3);
    send(32'h0220E1B3);
    step(0, 32'h0, 1, 0, acc);
`else
    check("mul_halt", halted, 1);
    check("mul_ov", out_valid, 0);
`endif
    do_reset();

    // Illegal instructions: bubble, halt, count, blocked until reset
    foreach (illegal_tab[n]) begin
      send(32'h002081B3);
      step(1, illegal_tab[n], 1, 0, acc);
      check("ill_ov", out_valid, 0);
      check("ill_halted", halted, 1);
      check("ill_cnt", illegal_cnt, 8'd1);
      for (int k = 0; k < 3; k++) begin
        step(1, 32'h002081B3, 1, 0, acc);
        check("halt_in_ready", in_ready, 0);
      end
      do_reset();
      step(1, 32'h00309313, 1, 0, acc);
      check("post_rst_acc", acc, 1);
      check("post_rst_ov", out_valid, 1);
      step(0, 32'h0, 1, 0, acc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
